// File: rtl/list_sum_pkg.sv
// list_sum_pkg: shared FSM states and constants for the list-summing scheduler
package list_sum_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;
    localparam int NULL_PTR = 0;
endpackage

// File: rtl/list_sum_sched_if.sv
// list_sum_sched_if: requester, node-memory and result signals of the scheduler
interface list_sum_sched_if #(parameter int N_REQ = 4, parameter int AW = 8, parameter int DW = 16);
    localparam int IW = $clog2(N_REQ);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*AW-1:0] head;
    logic [N_REQ-1:0]    gnt;
    logic                busy;
    logic                mem_rd_en;
    logic [AW-1:0]       mem_addr;
    logic                mem_rd_valid;
    logic [DW-1:0]       mem_data;
    logic [AW-1:0]       mem_next;
    logic                res_valid;
    logic [IW-1:0]       res_id;
    logic [DW-1:0]       res_sum;
    logic                res_ovf;
    logic                res_err;
    modport master (
        output req, head, mem_rd_valid, mem_data, mem_next,
        input  gnt, busy, mem_rd_en, mem_addr, res_valid, res_id, res_sum, res_ovf, res_err
    );
    modport slave (
        input  req, head, mem_rd_valid, mem_data, mem_next,
        output gnt, busy, mem_rd_en, mem_addr, res_valid, res_id, res_sum, res_ovf, res_err
    );
endinterface

// File: rtl/list_sum_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after last
module rr_arbiter #(parameter int N_REQ = 4, localparam int IW = $clog2(N_REQ)) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);
    logic [IW-1:0] j;
    // Scan from farthest to nearest so the nearest requester after last wins
    always_comb begin
        gnt = '0;
        idx = '0;
        j = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = IW'((int'(last) + k) % N_REQ);
            if (req[j]) begin
                gnt = N_REQ'(1) << j;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/list_sum_sched.sv
// list_sum_sched: round-robin scheduler sharing one linked-list summing datapath
module list_sum_sched
    import list_sum_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int AW        = 8,
    parameter int DW        = 16,
    parameter int MAX_NODES = 255
) (
    input logic clk,
    input logic rst,
    list_sum_sched_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_NODES + 1);
    state_t           state;
    logic [IW-1:0]    id, rr_last, arb_idx;
    logic [N_REQ-1:0] arb_gnt;
    logic [AW-1:0]    ptr, h;
    logic [DW-1:0]    sum;
    logic [CW-1:0]    cnt;
    logic             ovf, nxt_null, last_node;
    logic [DW:0]      acc;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (.req(bus.req), .last(rr_last), .gnt(arb_gnt), .idx(arb_idx));

    assign h = bus.head[arb_idx*AW +: AW];
    assign acc = {1'b0, sum} + {1'b0, bus.mem_data};
    assign nxt_null = bus.mem_next == AW'(NULL_PTR);
    assign last_node = nxt_null || cnt == CW'(MAX_NODES - 1);
    assign bus.mem_addr = ptr;
    assign bus.busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            id            <= '0;
            rr_last       <= IW'(N_REQ - 1);
            ptr           <= '0;
            sum           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.gnt       <= '0;
            bus.mem_rd_en <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_sum   <= '0;
            bus.res_ovf   <= 1'b0;
            bus.res_err   <= 1'b0;
        end else begin
            bus.res_valid <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            case (state)
                IDLE: if (|bus.req) begin
                    id      <= arb_idx;
                    bus.gnt <= arb_gnt;
                    ptr     <= h;
                    sum     <= '0;
                    cnt     <= '0;
                    ovf     <= 1'b0;
                    if (h == AW'(NULL_PTR)) begin
                        state         <= DONE;
                        bus.res_valid <= 1'b1;
                        bus.res_id    <= arb_idx;
                        bus.res_sum   <= '0;
                        bus.res_ovf   <= 1'b0;
                        bus.res_err   <= 1'b0;
                    end else begin
                        state         <= FETCH;
                        bus.mem_rd_en <= 1'b1;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: if (bus.mem_rd_valid) begin
                    sum <= acc[DW-1:0];
                    ovf <= ovf | acc[DW];
                    ptr <= bus.mem_next;
                    cnt <= cnt + 1'b1;
                    if (last_node) begin
                        state         <= DONE;
                        bus.res_valid <= 1'b1;
                        bus.res_id    <= id;
                        bus.res_sum   <= acc[DW-1:0];
                        bus.res_ovf   <= ovf | acc[DW];
                        bus.res_err   <= !nxt_null;
                    end else begin
                        state         <= FETCH;
                        bus.mem_rd_en <= 1'b1;
                    end
                end
                DONE: begin
                    bus.gnt <= '0;
                    rr_last <= id;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
